// File: rtl/stream_window_gen.sv
// Streaming WINxWIN window generator: raster pixels in, one window per interior
// centre pixel out, with valid/ready on both sides and frame status pulses.
module stream_window_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned WIN    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_pixel,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIN*WIN*DATA_W-1:0]  out_window,
  output logic                       out_last,
  output logic                       out_fend,
  output logic                       frame_done,
  output logic                       frame_err
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned NBUF  = WIN - 1;
  localparam int unsigned TAPS  = WIN * WIN;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN - 1);

  logic [COL_W-1:0]  col_q, pos_col, col_nxt, rd_addr;
  logic [ROW_W-1:0]  row_q, pos_row, row_nxt;
  logic              accept, qualify, at_col_last, at_frame_end;

  logic [DATA_W-1:0] lb_rd   [NBUF];
  logic [DATA_W-1:0] new_col [WIN];
  logic [DATA_W-1:0] win_q   [WIN][WIN];
  logic [DATA_W-1:0] win_nxt [WIN][WIN];
  logic [TAPS*DATA_W-1:0] win_flat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Position of the pixel being accepted; in_sof forces it to (0,0).
  always_comb begin
    pos_col      = in_sof ? '0 : col_q;
    pos_row      = in_sof ? '0 : row_q;
    at_col_last  = (pos_col == COL_LAST);
    at_frame_end = at_col_last && (pos_row == ROW_LAST);
    qualify      = accept && (pos_row >= ROW_FIRST) && (pos_col >= COL_FIRST);
    col_nxt      = at_col_last ? '0 : pos_col + COL_W'(1);
    row_nxt      = pos_row;
    if (at_col_last) begin
      row_nxt = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
    end
    // Prefetch the column the next accept will use so the read data is ready.
    rd_addr      = accept ? col_nxt : col_q;
  end

  // Line-buffer cascade: buffer g holds the pixel g+1 rows above the current one.
  for (genvar g = 0; g < NBUF; g++) begin : g_lb
    logic [DATA_W-1:0] mem [IMG_W];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] wr_d;

    if (g == 0) begin : g_head
      assign wr_d = in_pixel;
    end else begin : g_tail
      assign wr_d = lb_rd[g-1];
    end

    always_ff @(posedge clk) begin
      if (accept) begin
        mem[pos_col] <= wr_d;
      end
      rd_q <= mem[rd_addr];
    end

    assign lb_rd[g]            = rd_q;
    assign new_col[NBUF-1-g]   = rd_q;
  end

  assign new_col[NBUF] = in_pixel;

  // Shift window left by one column and append the new column on the right.
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win_nxt[r][c] = win_q[r][c+1];
      end
      win_nxt[r][WIN-1] = new_col[r];
    end
    win_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_flat[(TAPS-1-(r*WIN+c))*DATA_W +: DATA_W] = win_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
      out_last   <= 1'b0;
      out_fend   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      frame_done <= accept && at_frame_end;
      frame_err  <= accept && in_sof && ((col_q != '0) || (row_q != '0));
      if (accept) begin
        col_q <= col_nxt;
        row_q <= row_nxt;
        win_q <= win_nxt;
      end
      if (qualify) begin
        out_valid  <= 1'b1;
        out_window <= win_flat;
        out_last   <= at_col_last;
        out_fend   <= at_frame_end;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_window_gen.sv
// Bench for stream_window_gen: directed test-plan scenarios plus randomized
// traffic, checked against an image-array reference model.
module tb_stream_window_gen;

  typedef struct packed {
    logic [199:0] w;
    logic         last;
    logic         fend;
  } exp_t;

  localparam logic [199:0] W0  = 200'({8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
  localparam logic [199:0] W1  = 200'({8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
  localparam logic [199:0] W2  = 200'({8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14});
  localparam logic [199:0] W3  = 200'({8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15});
  localparam logic [199:0] OFF = 200'({9{8'd16}});

  logic         clk, rst, in_valid, in_sof, out_ready;
  logic [7:0]   in_pixel;
  logic         ready3, valid3, last3, fend3, done3, err3;
  logic [71:0]  win3;
  logic         ready5, valid5, last5, fend5, done5, err5;
  logic [199:0] win5;

  stream_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .WIN(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready3), .in_pixel(in_pixel),
    .in_sof(in_sof), .out_valid(valid3), .out_ready(out_ready), .out_window(win3),
    .out_last(last3), .out_fend(fend3), .frame_done(done3), .frame_err(err3));

  stream_window_gen #(.DATA_W(8), .IMG_W(6), .IMG_H(6), .WIN(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready5), .in_pixel(in_pixel),
    .in_sof(in_sof), .out_valid(valid5), .out_ready(out_ready), .out_window(win5),
    .out_last(last5), .out_fend(fend5), .frame_done(done5), .frame_err(err5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass, n_total;
  int   sel, mw, mh, mwin, mrow, mcol;
  int   pix [6][6];
  exp_t exp_q[$];
  exp_t obs_q[$];
  int   exp_done, exp_err, obs_done, obs_err;
  logic s_acc, s_valid, s_ready, s_last, s_fend;
  logic [199:0] s_win;

  // Reference: store pixels by image position and cut windows out of the array.
  task automatic model_accept(input int p, input bit sof);
    exp_t e;
    if (sof) begin
      if (mrow != 0 || mcol != 0) exp_err++;
      mrow = 0;
      mcol = 0;
    end
    pix[mrow][mcol] = p;
    if (mrow >= mwin - 1 && mcol >= mwin - 1) begin
      e.w = '0;
      for (int r = 0; r < mwin; r++)
        for (int c = 0; c < mwin; c++)
          e.w = {e.w[191:0], 8'(pix[mrow-mwin+1+r][mcol-mwin+1+c])};
      e.last = (mcol == mw - 1);
      e.fend = e.last && (mrow == mh - 1);
      exp_q.push_back(e);
    end
    if (mrow == mh - 1 && mcol == mw - 1) exp_done++;
    mcol++;
    if (mcol == mw) begin
      mcol = 0;
      mrow++;
      if (mrow == mh) mrow = 0;
    end
  endtask

  task automatic clear_model();
    mrow = 0; mcol = 0;
    exp_q.delete(); obs_q.delete();
    exp_done = 0; exp_err = 0; obs_done = 0; obs_err = 0;
  endtask

  // One clock: drive inputs, log handshakes, then sample registered outputs.
  task automatic step(input bit v, input int p, input bit sof, input bit rdy);
    exp_t o;
    in_valid = v; in_pixel = 8'(p); in_sof = sof; out_ready = rdy;
    #1;
    s_acc = v && (sel != 0 ? ready5 : ready3);
    if ((sel != 0 ? valid5 : valid3) && rdy) begin
      o.w    = (sel != 0) ? win5 : 200'(win3);
      o.last = (sel != 0) ? last5 : last3;
      o.fend = (sel != 0) ? fend5 : fend3;
      obs_q.push_back(o);
    end
    if (s_acc) model_accept(p, sof);
    @(posedge clk);
    #2;
    s_valid = (sel != 0) ? valid5 : valid3;
    s_ready = (sel != 0) ? ready5 : ready3;
    s_win   = (sel != 0) ? win5 : 200'(win3);
    s_last  = (sel != 0) ? last5 : last3;
    s_fend  = (sel != 0) ? fend5 : fend3;
    if ((sel != 0) ? done5 : done3) obs_done++;
    if ((sel != 0) ? err5 : err3) obs_err++;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    mw = (s != 0) ? 6 : 4; mh = mw; mwin = (s != 0) ? 5 : 3;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sel != 0 ? valid5 : valid3); i++) step(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    sel = 0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1; in_pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (valid3 !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid3); else n_pass++;
    n_total++; if (ready3 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready3); else n_pass++;
    n_total++; if (win3 !== 72'd0) $display("FAIL reset_window: got %h want 0", win3); else n_pass++;
    n_total++;
    if ({last3, fend3, done3, err3} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {last3, fend3, done3, err3});
    else n_pass++;
  endtask

  task automatic test_full_rate();
    exp_t o;
    do_reset(0);
    for (int i = 0; i < 16; i++) begin
      step(1, i, 0, 1);
      if (i == 9) begin
        n_total++; if (s_valid !== 1'b0) $display("FAIL early_valid: got %b want 0", s_valid); else n_pass++;
      end
      if (i == 10) begin
        n_total++; if (s_valid !== 1'b1) $display("FAIL latency_valid: got %b want 1", s_valid); else n_pass++;
        n_total++; if (s_win !== W0) $display("FAIL first_window: got %h want %h", s_win, W0); else n_pass++;
      end
    end
    drain();
    n_total++; if (obs_q.size() != 4) $display("FAIL full_count: got %0d want 4", obs_q.size()); else n_pass++;
    o = obs_q[1];
    n_total++; if (o !== {W1, 1'b1, 1'b0}) $display("FAIL second_window: got %h want %h", o, {W1, 2'b10}); else n_pass++;
    o = obs_q[3];
    n_total++; if (o !== {W3, 1'b1, 1'b1}) $display("FAIL last_window: got %h want %h", o, {W3, 2'b11}); else n_pass++;
    n_total++; if (obs_done != 1) $display("FAIL full_done: got %0d want 1", obs_done); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_total++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) $display("FAIL full_model%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [199:0] wc [4];
    wc[0] = W0; wc[1] = W1; wc[2] = W2; wc[3] = W3;
    do_reset(0);
    for (int i = 0; i <= 10; i++) step(1, i, 0, 1);
    for (int t = 0; t < 5; t++) begin
      step(1, 11, 0, 0);
      n_total++; if (s_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b want 1", t, s_valid); else n_pass++;
      n_total++; if (s_win !== W0) $display("FAIL stall_window%0d: got %h want %h", t, s_win, W0); else n_pass++;
      n_total++; if (s_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", t, s_ready); else n_pass++;
    end
    for (int i = 11; i < 16; i++) step(1, i, 0, 1);
    drain();
    n_total++; if (obs_q.size() != 4) $display("FAIL stall_count: got %0d want 4", obs_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (k >= obs_q.size() || obs_q[k].w !== wc[k]) $display("FAIL stall_win%0d: got %h want %h", k, obs_q[k].w, wc[k]);
      else n_pass++;
    end
  endtask

  task automatic test_win5();
    exp_t o;
    do_reset(1);
    for (int i = 0; i < 36; i++) step(1, i, 0, 1);
    drain();
    n_total++; if (obs_q.size() != 4) $display("FAIL win5_count: got %0d want 4", obs_q.size()); else n_pass++;
    o = obs_q[0];
    n_total++; if (o.w[103:96] !== 8'd14) $display("FAIL win5_centre: got %0d want 14", o.w[103:96]); else n_pass++;
    n_total++; if (o.w[7:0] !== 8'd28) $display("FAIL win5_bottom_right: got %0d want 28", o.w[7:0]); else n_pass++;
    n_total++; if (o.w[199:192] !== 8'd0) $display("FAIL win5_top_left: got %0d want 0", o.w[199:192]); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_total++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) $display("FAIL win5_model%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [199:0] wc [4];
    wc[0] = W0; wc[1] = W1; wc[2] = W2; wc[3] = W3;
    do_reset(0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) step(1, f * 16 + i, i == 0, 1);
    drain();
    n_total++; if (obs_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", obs_q.size()); else n_pass++;
    n_total++; if (obs_err != 0) $display("FAIL b2b_err: got %0d want 0", obs_err); else n_pass++;
    n_total++; if (obs_done != 2) $display("FAIL b2b_done: got %0d want 2", obs_done); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (k + 4 >= obs_q.size() || obs_q[k+4].w !== wc[k] + OFF)
        $display("FAIL b2b_offset%0d: got %h want %h", k, obs_q[k+4].w, wc[k] + OFF);
      else n_pass++;
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_total++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) $display("FAIL b2b_model%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_sof_err();
    do_reset(0);
    for (int i = 0; i < 6; i++) step(1, i, 0, 1);
    step(1, 100, 1, 1);
    for (int i = 1; i < 16; i++) step(1, 100 + i, 0, 1);
    drain();
    n_total++; if (obs_err != 1) $display("FAIL sof_err_pulses: got %0d want 1", obs_err); else n_pass++;
    n_total++; if (obs_q.size() != 4) $display("FAIL sof_count: got %0d want 4", obs_q.size()); else n_pass++;
    n_total++; if (obs_done != 1) $display("FAIL sof_done: got %0d want 1", obs_done); else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_total++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) $display("FAIL sof_model%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [199:0] wc [4];
    wc[0] = W0; wc[1] = W1; wc[2] = W2; wc[3] = W3;
    do_reset(0);
    for (int i = 0; i <= 10; i++) step(1, i, 0, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (valid3 !== 1'b0) $display("FAIL async_rst_valid: got %b want 0", valid3); else n_pass++;
    n_total++; if (win3 !== 72'd0) $display("FAIL async_rst_window: got %h want 0", win3); else n_pass++;
    @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 16; i++) step(1, i, 0, 1);
    drain();
    n_total++; if (obs_q.size() != 4) $display("FAIL rst_mid_count: got %0d want 4", obs_q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (k >= obs_q.size() || obs_q[k].w !== wc[k]) $display("FAIL rst_mid_win%0d: got %h want %h", k, obs_q[k].w, wc[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      do_reset(s);
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < mw * mh; i++) begin
          int p;
          p = int'($urandom_range(0, 255));
          for (int t = 0; t < 64; t++) begin
            step($urandom_range(0, 99) < 75, p, i == 0, $urandom_range(0, 99) < 70);
            if (s_acc) break;
          end
        end
      end
      drain();
      n_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", s, obs_q.size(), exp_q.size());
      else n_pass++;
      n_total++; if (obs_done != exp_done) $display("FAIL rand%0d_done: got %0d want %0d", s, obs_done, exp_done); else n_pass++;
      n_total++; if (obs_err != exp_err) $display("FAIL rand%0d_err: got %0d want %0d", s, obs_err, exp_err); else n_pass++;
      for (int k = 0; k < exp_q.size(); k++) begin
        n_total++;
        if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
          $display("FAIL rand%0d_win%0d: got %h want %h", s, k, obs_q[k], exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1; in_pixel = '0;
    sel = 0; mw = 4; mh = 4; mwin = 3;
    clear_model();
    test_reset();
    test_full_rate();
    test_stall();
    test_win5();
    test_back_to_back();
    test_sof_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
